// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port memo between the CPU and DMA ports and decodes I/O at ADDR_IO.
// Define ARB_ROUND_ROBIN_EN to replace CPU priority and the MAX_HOLD starvation guard with alternating grants.

module mem_port_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_IO    = 252,
   parameter int MAX_HOLD   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [DATA_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [DATA_WIDTH-1:0] dma_addr,
   input  logic [DATA_WIDTH-1:0] dma_wdata,
   output logic                  dma_gnt,
   output logic                  dma_rvalid,
   output logic [DATA_WIDTH-1:0] dma_rdata,
   output logic [DATA_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_wren,
   input  logic [DATA_WIDTH-1:0] mem_q,
   input  logic [DATA_WIDTH-1:0] E,
   output logic [DATA_WIDTH-1:0] S
);

   localparam logic [DATA_WIDTH-1:0] IO_ADDR = DATA_WIDTH'(ADDR_IO);

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_DMA = 1'b1
   } owner_t;

   logic                  w_dmaWins;
   logic                  w_cpuGnt;
   logic                  w_dmaGnt;
   logic                  w_anyGnt;
   logic                  w_we;
   logic [DATA_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_isIo;
   logic [DATA_WIDTH-1:0] w_rspData;

   logic [DATA_WIDTH-1:0] r_lastAddr;
   logic                  r_pendValid;
   owner_t                r_pendOwner;
   logic                  r_pendIo;
   logic [DATA_WIDTH-1:0] r_eSample;
   logic [DATA_WIDTH-1:0] r_cpuRdata;
   logic [DATA_WIDTH-1:0] r_dmaRdata;

`ifdef ARB_ROUND_ROBIN_EN
   owner_t                r_last;
`else
   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
   logic [3:0]            r_holdCnt;
`endif

   // Arbitration decides only whether DMA wins; the CPU takes every cycle DMA does not.
   always_comb begin
      w_dmaWins = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      if (cpu_req && dma_req)
         w_dmaWins = (r_last == OWNER_CPU);
      else
         w_dmaWins = dma_req;
`else
      w_dmaWins = dma_req && (!cpu_req || (r_holdCnt == HOLD_MAX));
`endif
   end

   assign w_cpuGnt = reset && cpu_req && !w_dmaWins;
   assign w_dmaGnt = reset && dma_req && w_dmaWins;
   assign w_anyGnt = w_cpuGnt || w_dmaGnt;

   assign w_we     = w_dmaGnt ? dma_we    : cpu_we;
   assign w_addr   = w_dmaGnt ? dma_addr  : cpu_addr;
   assign w_wdata  = w_dmaGnt ? dma_wdata : cpu_wdata;
   assign w_isIo   = (w_addr == IO_ADDR);

   assign cpu_gnt     = w_cpuGnt;
   assign dma_gnt     = w_dmaGnt;
   assign mem_address = w_anyGnt ? w_addr : r_lastAddr;
   assign mem_data    = w_wdata;
   assign mem_wren    = w_anyGnt && w_we && !w_isIo;

   // I/O reads return the E value captured at the grant edge instead of memo's output.
   assign w_rspData  = r_pendIo ? r_eSample : mem_q;

   assign cpu_rvalid = r_pendValid && (r_pendOwner == OWNER_CPU);
   assign dma_rvalid = r_pendValid && (r_pendOwner == OWNER_DMA);
   assign cpu_rdata  = cpu_rvalid ? w_rspData : r_cpuRdata;
   assign dma_rdata  = dma_rvalid ? w_rspData : r_dmaRdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         S           <= '0;
         r_lastAddr  <= '0;
         r_pendValid <= 1'b0;
         r_pendOwner <= OWNER_CPU;
         r_pendIo    <= 1'b0;
         r_eSample   <= '0;
         r_cpuRdata  <= '0;
         r_dmaRdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         r_last      <= OWNER_CPU;
`else
         r_holdCnt   <= '0;
`endif
      end else begin
         if (w_anyGnt)
            r_lastAddr <= w_addr;

         r_pendValid <= w_anyGnt && !w_we;
         r_pendOwner <= w_dmaGnt ? OWNER_DMA : OWNER_CPU;
         r_pendIo    <= w_isIo;

         if (w_anyGnt && !w_we && w_isIo)
            r_eSample <= E;
         if (w_anyGnt && w_we && w_isIo)
            S <= w_wdata;

         // Capture the delivered response so rdata holds it once rvalid drops.
         if (cpu_rvalid)
            r_cpuRdata <= w_rspData;
         if (dma_rvalid)
            r_dmaRdata <= w_rspData;

`ifdef ARB_ROUND_ROBIN_EN
         if (w_anyGnt)
            r_last <= w_dmaGnt ? OWNER_DMA : OWNER_CPU;
`else
         if (w_dmaGnt || !dma_req)
            r_holdCnt <= '0;
         else if (w_cpuGnt && (r_holdCnt != HOLD_MAX))
            r_holdCnt <= r_holdCnt + 4'd1;
`endif
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a behavioural model.
// Includes a simple registered-read memo model driven by the arbiter's mem_* outputs.

module tb_mem_port_arbiter;

   localparam int MAX_HOLD = 4;
   localparam logic [7:0] IO = 8'd252;

   logic       clk;
   logic       reset;
   logic       cpu_req, cpu_we, dma_req, dma_we;
   logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic       cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
   logic [7:0] cpu_rdata, dma_rdata;
   logic [7:0] mem_address, mem_data, mem_q, E, S;
   logic       mem_wren;

   mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_IO(252), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
      .E(E), .S(S)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memo: synchronous write, registered read with one cycle of latency
   logic [7:0] memArr [256];
   always @(posedge clk) begin
      if (mem_wren)
         memArr[mem_address] <= mem_data;
      mem_q <= memArr[mem_address];
   end

   int nChecks = 0;
   int nMiss   = 0;

   // Reference model state
   logic [7:0] refMem [256];
   int         holdCount;
   bit         lastDma;
   logic [7:0] expS, lastAddr, cpuHeld, dmaHeld, pendData;
   bit         pend, pendDma;
   bit         expCpuG, expDmaG;

   task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nMiss++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      nChecks++;
      assert (obs === exp) else begin
         nMiss++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      holdCount = 0;
      lastDma   = 1'b0;
      expS      = 8'h00;
      lastAddr  = 8'h00;
      cpuHeld   = 8'h00;
      dmaHeld   = 8'h00;
      pend      = 1'b0;
      pendDma   = 1'b0;
      pendData  = 8'h00;
   endtask

   task automatic applyStimulus(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                                input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd,
                                input logic [7:0] e);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
      E = e;
   endtask

   // Checks one cycle mid-period, advances the model, and returns 1 time unit after the next rising edge.
   task automatic checkOutput();
      bit         dmaWins, gAny, gWe, cpuRvExp, dmaRvExp;
      logic [7:0] gAddr, gData;
      @(negedge clk);
      if (reset === 1'b0)
         modelReset();
`ifdef ARB_ROUND_ROBIN_EN
      dmaWins = (cpu_req && dma_req) ? !lastDma : dma_req;
`else
      dmaWins = dma_req && (!cpu_req || (holdCount == MAX_HOLD));
`endif
      expCpuG = reset && cpu_req && !dmaWins;
      expDmaG = reset && dma_req && dmaWins;
      gAny    = expCpuG || expDmaG;
      gWe     = expDmaG ? dma_we    : cpu_we;
      gAddr   = expDmaG ? dma_addr  : cpu_addr;
      gData   = expDmaG ? dma_wdata : cpu_wdata;
      cpuRvExp = pend && !pendDma;
      dmaRvExp = pend && pendDma;

      checkBit("cpu_gnt", cpu_gnt, expCpuG);
      checkBit("dma_gnt", dma_gnt, expDmaG);
      checkBit("mem_wren", mem_wren, gAny && gWe && (gAddr != IO));
      checkVal("mem_address", mem_address, gAny ? gAddr : lastAddr);
      if (gAny && gWe)
         checkVal("mem_data", mem_data, gData);
      checkBit("cpu_rvalid", cpu_rvalid, cpuRvExp);
      checkBit("dma_rvalid", dma_rvalid, dmaRvExp);
      checkVal("cpu_rdata", cpu_rdata, cpuRvExp ? pendData : cpuHeld);
      checkVal("dma_rdata", dma_rdata, dmaRvExp ? pendData : dmaHeld);
      checkVal("S", S, expS);

      if (reset === 1'b1) begin
         if (cpuRvExp) cpuHeld = pendData;
         if (dmaRvExp) dmaHeld = pendData;
         pend    = gAny && !gWe;
         pendDma = expDmaG;
         if (pend)
            pendData = (gAddr == IO) ? E : refMem[gAddr];
         if (gAny && gWe) begin
            if (gAddr == IO) expS = gData;
            else             refMem[gAddr] = gData;
         end
         if (expDmaG || !dma_req)
            holdCount = 0;
         else if (expCpuG && holdCount < MAX_HOLD)
            holdCount++;
         if (gAny) begin
            lastDma  = expDmaG;
            lastAddr = gAddr;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] randAddr();
      int unsigned pick;
      pick = $urandom_range(0, 16);
      return (pick == 16) ? IO : 8'(pick);
   endfunction

   logic       cR, cW, dR, dW;
   logic [7:0] cA, cD, dA, dD;

   initial begin
      modelReset();
      applyStimulus(1, 1, 8'd7, 8'hAA, 1, 1, 8'd8, 8'hBB, 8'h00);
      reset = 1'b1;
      #2 reset = 1'b0;
      // Requests held high during reset must not produce grants
      checkOutput();
      checkOutput();
      reset = 1'b1;
      applyStimulus(0, 0, 8'd0, 8'd0, 0, 0, 8'd0, 8'd0, 8'h00);
      checkOutput();

      // DMA alone preloads addresses 0..15 on consecutive cycles
      for (int a = 0; a < 16; a++) begin
         applyStimulus(0, 0, 8'd0, 8'd0, 1, 1, 8'(a), 8'($urandom), 8'h00);
         checkOutput();
      end

      // CPU write then read of ordinary memory
      applyStimulus(1, 1, 8'd10, 8'h5A, 0, 0, 8'd0, 8'd0, 8'h00);
      checkOutput();
      applyStimulus(1, 0, 8'd10, 8'h00, 0, 0, 8'd0, 8'd0, 8'h00);
      checkOutput();
      checkBit("rd10_valid", cpu_rvalid, 1'b1);
      checkVal("rd10_data", cpu_rdata, 8'h5A);
      applyStimulus(0, 0, 8'd0, 8'd0, 0, 0, 8'd0, 8'd0, 8'h00);
      checkOutput();

      // Memory-mapped output write and input read
      applyStimulus(1, 1, IO, 8'h3C, 0, 0, 8'd0, 8'd0, 8'h00);
      checkOutput();
      checkVal("S_io_write", S, 8'h3C);
      applyStimulus(1, 0, IO, 8'h00, 0, 0, 8'd0, 8'd0, 8'h81);
      checkOutput();
      checkVal("rd_io_data", cpu_rdata, 8'h81);
      applyStimulus(0, 0, 8'd0, 8'd0, 0, 0, 8'd0, 8'd0, 8'h00);
      checkOutput();

      // Both requesters held high continuously
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1, 0, 8'd3, 8'd0, 1, 0, 8'd4, 8'd0, 8'h00);
`ifndef ARB_ROUND_ROBIN_EN
         #1;
         checkBit("hold_pattern", dma_gnt, (i % 5) == 4);
`endif
         checkOutput();
      end
      applyStimulus(0, 0, 8'd0, 8'd0, 0, 0, 8'd0, 8'd0, 8'h00);
      checkOutput();

      // Alternating CPU and DMA reads, responses routed to their owners
      applyStimulus(1, 1, 8'd1, 8'h11, 0, 0, 8'd0, 8'd0, 8'h00);
      checkOutput();
      applyStimulus(1, 1, 8'd2, 8'h22, 0, 0, 8'd0, 8'd0, 8'h00);
      checkOutput();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 8'd1, 8'd0, 0, 0, 8'd0, 8'd0, 8'h00);
         checkOutput();
         checkVal("alt_cpu_data", cpu_rdata, 8'h11);
         checkBit("alt_dma_quiet", dma_rvalid, 1'b0);
         applyStimulus(0, 0, 8'd0, 8'd0, 1, 0, 8'd2, 8'd0, 8'h00);
         checkOutput();
         checkVal("alt_dma_data", dma_rdata, 8'h22);
         checkBit("alt_cpu_quiet", cpu_rvalid, 1'b0);
      end

      // Reset asserted in the cycle after a CPU read grant
      applyStimulus(1, 0, 8'd5, 8'd0, 0, 0, 8'd0, 8'd0, 8'h00);
      checkOutput();
      reset = 1'b0;
      applyStimulus(1, 0, 8'd6, 8'd0, 1, 0, 8'd7, 8'd0, 8'h00);
      checkOutput();
      reset = 1'b1;
      applyStimulus(0, 0, 8'd0, 8'd0, 0, 0, 8'd0, 8'd0, 8'h00);
      checkOutput();
      checkBit("no_reissue", cpu_rvalid, 1'b0);

      // Randomized traffic that keeps each request stable until granted
      cR = 0; cW = 0; cA = 0; cD = 0;
      dR = 0; dW = 0; dA = 0; dD = 0;
      for (int n = 0; n < 400; n++) begin
         if (!cR || expCpuG) begin
            cR = ($urandom_range(0, 99) < 60);
            cW = $urandom_range(0, 1) == 1;
            cA = randAddr();
            cD = 8'($urandom);
         end else if ($urandom_range(0, 99) < 5) begin
            cR = 1'b0;
         end
         if (!dR || expDmaG) begin
            dR = ($urandom_range(0, 99) < 60);
            dW = $urandom_range(0, 1) == 1;
            dA = randAddr();
            dD = 8'($urandom);
         end else if ($urandom_range(0, 99) < 5) begin
            dR = 1'b0;
         end
         applyStimulus(cR, cW, cA, cD, dR, dW, dA, dD, 8'($urandom));
         checkOutput();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiss);
      $finish;
   end

endmodule
